// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings and shadow-pipeline entry types for the MIPS hazard/forwarding control.
// Register-index width is fixed here; the top-level REG_W must equal GPR_W.
package mips_hazard_pkg;

    localparam int GPR_W = 5;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_RESULTW = 2'b01;
    localparam logic [1:0] FWD_ALUOUTM = 2'b10;

    localparam logic [GPR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [GPR_W-1:0] rs;
        logic [GPR_W-1:0] rt;
        logic [GPR_W-1:0] wr;
        logic             reg_write;
        logic             mem_to_reg;
    } e_entry_t;

    typedef struct packed {
        logic [GPR_W-1:0] wr;
        logic             reg_write;
        logic             mem_to_reg;
    } m_entry_t;

    typedef struct packed {
        logic [GPR_W-1:0] wr;
        logic             reg_write;
    } w_entry_t;

    // M wins over W because it holds the younger producer.
    function automatic logic [1:0] fwd_sel(
        input logic [GPR_W-1:0] src,
        input logic [GPR_W-1:0] m_wr,
        input logic             m_we,
        input logic [GPR_W-1:0] w_wr,
        input logic             w_we
    );
        if (src != REG_ZERO && m_we && m_wr == src) return FWD_ALUOUTM;
        if (src != REG_ZERO && w_we && w_wr == src) return FWD_RESULTW;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// D-stage hazard inputs and forwarding/stall outputs of the execute-stage hazard unit.
// master = pipeline datapath side, slave = hazard_forward_ctrl.
interface hazard_forward_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic             UseRsD;
    logic             UseRtD;
    logic             BranchD;
    logic             JrD;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic [REG_W-1:0] WriteRegD;
    logic             MdStartD;
    logic             MdDivD;
    logic             MdReadD;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             ForwardAD;
    logic             ForwardBD;
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic             MdBusy;

    modport master (
        output RsD, RtD, UseRsD, UseRtD, BranchD, JrD, RegWriteD, MemtoRegD,
               WriteRegD, MdStartD, MdDivD, MdReadD,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD,
               FlushE, MdBusy
    );

    modport slave (
        input  RsD, RtD, UseRsD, UseRtD, BranchD, JrD, RegWriteD, MemtoRegD,
               WriteRegD, MdStartD, MdDivD, MdReadD,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD,
               FlushE, MdBusy
    );
endinterface

// File: rtl/hazard_forward_ctrl_md_busy_counter.sv
// Busy countdown for the multi-cycle mult/div unit: loads on issue, decrements to zero.
// Busy is registered; load takes effect the cycle after the issuing instruction leaves D.
module md_busy_counter #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: E-stage forward selects, D-stage branch forwards, stalls and E flush.
// Outputs are combinational from D inputs and shadow E/M/W state; a stall holds F/D and bubbles E.
module hazard_forward_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int REG_W       = GPR_W,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_forward_ctrl_if.slave   hz
);

    e_entry_t   e_q;
    e_entry_t   e_d;
    m_entry_t   m_q;
    w_entry_t   w_q;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       fwd_ad;
    logic       fwd_bd;
    logic       rs_hit;
    logic       rt_hit;
    logic       lw_stall;
    logic       br_stall;
    logic       md_stall;
    logic       stall;
    logic       md_busy;
    logic       md_start;

    // Unread source indices are zeroed so they can never match a producer.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs         = hz.UseRsD ? hz.RsD : REG_ZERO;
            e_d.rt         = hz.UseRtD ? hz.RtD : REG_ZERO;
            e_d.wr         = hz.WriteRegD;
            e_d.reg_write  = hz.RegWriteD;
            e_d.mem_to_reg = hz.MemtoRegD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= '{wr: e_q.wr, reg_write: e_q.reg_write, mem_to_reg: e_q.mem_to_reg};
            w_q <= '{wr: m_q.wr, reg_write: m_q.reg_write};
        end
    end

    assign fwd_a = fwd_sel(e_q.rs, m_q.wr, m_q.reg_write, w_q.wr, w_q.reg_write);
    assign fwd_b = fwd_sel(e_q.rt, m_q.wr, m_q.reg_write, w_q.wr, w_q.reg_write);

    // A load in M has no ALU result yet, so only ALU producers feed the D-stage compare.
    assign fwd_ad = (hz.RsD != REG_ZERO) && m_q.reg_write && !m_q.mem_to_reg
                    && (m_q.wr == hz.RsD);
    assign fwd_bd = (hz.RtD != REG_ZERO) && m_q.reg_write && !m_q.mem_to_reg
                    && (m_q.wr == hz.RtD);

    assign lw_stall = e_q.reg_write && e_q.mem_to_reg && (e_q.wr != REG_ZERO)
                      && ((hz.UseRsD && hz.RsD == e_q.wr) || (hz.UseRtD && hz.RtD == e_q.wr));

    // Branch operands are needed in D: wait on any E producer and on a load still in M.
    assign rs_hit = (hz.RsD != REG_ZERO)
                    && ((e_q.reg_write && e_q.wr == hz.RsD)
                        || (m_q.reg_write && m_q.mem_to_reg && m_q.wr == hz.RsD));
    assign rt_hit = (hz.RtD != REG_ZERO)
                    && ((e_q.reg_write && e_q.wr == hz.RtD)
                        || (m_q.reg_write && m_q.mem_to_reg && m_q.wr == hz.RtD));

    assign br_stall = (hz.BranchD && (rs_hit || rt_hit)) || (hz.JrD && rs_hit);
    assign md_stall = md_busy && (hz.MdReadD || hz.MdStartD);
    assign stall    = lw_stall || br_stall || md_stall;

    // The counter only loads once the mult/div really leaves D.
    assign md_start = hz.MdStartD && !stall;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .div   (hz.MdDivD),
        .busy  (md_busy)
    );

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.ForwardAD = fwd_ad;
    assign hz.ForwardBD = fwd_bd;
    assign hz.StallF    = stall;
    assign hz.StallD    = stall;
    assign hz.FlushE    = stall;
    assign hz.MdBusy    = md_busy;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Instruction-sequence bench for hazard_forward_ctrl: each step presents one D-stage instruction
// and checks {ForwardAE,ForwardBE,ForwardAD,ForwardBD,StallF,StallD,FlushE,MdBusy} on the falling edge.
module tb_hazard_forward_ctrl;

    typedef struct {
        string      name;
        bit         rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        bit         urs;
        bit         urt;
        bit         br;
        bit         jr;
        bit         rw;
        bit         mtr;
        bit         mds;
        bit         mdd;
        bit         mdr;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    hazard_forward_ctrl_if #(.REG_W(5)) hz ();

    hazard_forward_ctrl #(
        .REG_W       (5),
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] exp_q[$];
    string      name_q[$];
    vec_t       tbl[$];

    function automatic vec_t nop_v();
        vec_t v;
        v.name = "nop"; v.rst_n = 1'b1;
        v.rs = '0; v.rt = '0; v.wr = '0;
        v.urs = 0; v.urt = 0; v.br = 0; v.jr = 0; v.rw = 0; v.mtr = 0;
        v.mds = 0; v.mdd = 0; v.mdr = 0;
        v.exp = '0;
        return v;
    endfunction

    function automatic vec_t alu(input int rd, input int rs, input int rt);
        vec_t v = nop_v();
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1; v.urt = 1; v.rw = 1; v.wr = 5'(rd);
        return v;
    endfunction

    function automatic vec_t addi(input int rt, input int rs);
        vec_t v = nop_v();
        v.rs = 5'(rs); v.urs = 1; v.rw = 1; v.wr = 5'(rt);
        return v;
    endfunction

    function automatic vec_t lw(input int rt, input int rs);
        vec_t v = addi(rt, rs);
        v.mtr = 1;
        return v;
    endfunction

    function automatic vec_t beq(input int rs, input int rt);
        vec_t v = nop_v();
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1; v.urt = 1; v.br = 1;
        return v;
    endfunction

    function automatic vec_t jr(input int rs, input int rt_field);
        vec_t v = nop_v();
        v.rs = 5'(rs); v.rt = 5'(rt_field); v.urs = 1; v.jr = 1;
        return v;
    endfunction

    function automatic vec_t md(input bit is_div, input int rs, input int rt);
        vec_t v = nop_v();
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1; v.urt = 1; v.mds = 1; v.mdd = is_div;
        return v;
    endfunction

    function automatic vec_t mflo(input int rd);
        vec_t v = nop_v();
        v.mdr = 1; v.rw = 1; v.wr = 5'(rd);
        return v;
    endfunction

    function automatic vec_t x(input vec_t v, input string nm, input logic [1:0] ae,
                               input logic [1:0] be, input bit ad, input bit bd,
                               input bit st, input bit busy);
        vec_t r = v;
        r.name = nm;
        r.exp  = {ae, be, ad, bd, st, st, st, busy};
        return r;
    endfunction

    task automatic step(input vec_t v);
        logic [9:0] act;
        logic [9:0] want;
        string      nm;
        rst_n        = v.rst_n;
        hz.RsD       = v.rs;
        hz.RtD       = v.rt;
        hz.UseRsD    = v.urs;
        hz.UseRtD    = v.urt;
        hz.BranchD   = v.br;
        hz.JrD       = v.jr;
        hz.RegWriteD = v.rw;
        hz.MemtoRegD = v.mtr;
        hz.WriteRegD = v.wr;
        hz.MdStartD  = v.mds;
        hz.MdDivD    = v.mdd;
        hz.MdReadD   = v.mdr;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        act  = {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD,
                hz.StallF, hz.StallD, hz.FlushE, hz.MdBusy};
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: {AE,BE,AD,BD,StallF,StallD,FlushE,MdBusy} got %b required %b",
                     nm, act, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t r;
        tbl.push_back(x(nop_v(),      "reset_idle",     2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(3, 1, 2), "add_r3",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(4, 3, 5), "sub_in_d",       2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "sub_fwd_m",      2'b10, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain1",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(6, 1, 2), "add_r6",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "gap1",           2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(7, 5, 6), "bd_from_m",      2'b00, 2'b00, 0, 1, 0, 0));
        tbl.push_back(x(nop_v(),      "be_from_w",      2'b00, 2'b01, 0, 0, 0, 0));
        tbl.push_back(x(alu(8, 1, 1), "add_r8_a",       2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(8, 2, 2), "add_r8_b",       2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(9, 8, 8), "ad_bd_from_m",   2'b00, 2'b00, 1, 1, 0, 0));
        tbl.push_back(x(nop_v(),      "m_beats_w",      2'b10, 2'b10, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain2",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(lw(2, 1),     "lw_r2",          2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(4, 2, 3), "lw_use_stall",   2'b00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(x(alu(4, 2, 3), "lw_use_release", 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "lw_fwd_w",       2'b01, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain3",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(addi(0, 1),   "addi_r0",        2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(4, 0, 0), "zero_src_d",     2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "zero_src_e",     2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain4",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(3, 1, 2), "add_r3_br",      2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(beq(3, 5),    "beq_alu_stall",  2'b00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(x(beq(3, 5),    "beq_ad_from_m",  2'b00, 2'b00, 1, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "beq_in_e_w",     2'b01, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain5",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(lw(3, 1),     "lw_r3_br",       2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(beq(3, 5),    "beq_lw_stall1",  2'b00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(x(beq(3, 5),    "beq_lw_stall2",  2'b00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(x(beq(3, 5),    "beq_lw_release", 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain6",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(31, 1, 2),"add_r31_a",      2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(jr(7, 31),    "jr_ignores_rt",  2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain7",         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(alu(31, 1, 2),"add_r31_b",      2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(jr(31, 0),    "jr_stall",       2'b00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(x(jr(31, 0),    "jr_ad_from_m",   2'b00, 2'b00, 1, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "jr_in_e_w",      2'b01, 2'b00, 0, 0, 0, 0));
        tbl.push_back(x(nop_v(),      "drain8",         2'b00, 2'b00, 0, 0, 0, 0));

        rst_n = 1'b0;
        hz.RsD = '0; hz.RtD = '0; hz.UseRsD = 0; hz.UseRtD = 0; hz.BranchD = 0; hz.JrD = 0;
        hz.RegWriteD = 0; hz.MemtoRegD = 0; hz.WriteRegD = '0;
        hz.MdStartD = 0; hz.MdDivD = 0; hz.MdReadD = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // div then mflo: held for exactly 32 cycles, released as MdBusy drops
        step(x(md(1, 1, 2), "div_issue", 2'b00, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++) step(x(mflo(4), "mflo_wait", 2'b00, 2'b00, 0, 0, 1, 1));
        step(x(mflo(4), "mflo_go", 2'b00, 2'b00, 0, 0, 0, 0));

        // back-to-back mult: second held 4 cycles, then its own 4 busy cycles
        step(x(md(0, 1, 2), "mult1", 2'b00, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) step(x(md(0, 5, 6), "mult2_wait", 2'b00, 2'b00, 0, 0, 1, 1));
        step(x(md(0, 5, 6), "mult2_go", 2'b00, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) step(x(nop_v(), "mult2_busy", 2'b00, 2'b00, 0, 0, 0, 1));
        step(x(nop_v(), "mult2_done", 2'b00, 2'b00, 0, 0, 0, 0));

        // mult blocked by a load-use stall must not start counting until it leaves D
        step(x(lw(2, 1), "lw_md", 2'b00, 2'b00, 0, 0, 0, 0));
        step(x(md(0, 2, 3), "md_lw_stall", 2'b00, 2'b00, 0, 0, 1, 0));
        step(x(md(0, 2, 3), "md_lw_go", 2'b00, 2'b00, 0, 0, 0, 0));
        step(x(nop_v(), "md_lw_busy_w", 2'b01, 2'b00, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) step(x(nop_v(), "md_lw_busy", 2'b00, 2'b00, 0, 0, 0, 1));
        step(x(nop_v(), "md_lw_done", 2'b00, 2'b00, 0, 0, 0, 0));

        // reset mid-div with live forwarding state (counter reads 10 in the reset cycle)
        step(x(md(1, 1, 2), "div2_issue", 2'b00, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) step(x(nop_v(), "div2_busy", 2'b00, 2'b00, 0, 0, 0, 1));
        step(x(alu(3, 1, 2), "div2_add", 2'b00, 2'b00, 0, 0, 0, 1));
        step(x(alu(4, 3, 5), "div2_sub", 2'b00, 2'b00, 0, 0, 0, 1));
        r = x(alu(6, 4, 3), "rst_cycle", 2'b10, 2'b00, 0, 1, 0, 1);
        r.rst_n = 1'b0;
        step(r);
        step(x(mflo(2), "post_rst_clear", 2'b00, 2'b00, 0, 0, 0, 0));
        step(x(nop_v(), "post_rst_idle", 2'b00, 2'b00, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Control end of the execute-stage forwarding mux in the 5-stage MIPS pipeline.
- Keeps its own shadow copy of E/M/W destination-register state.
- Generates ForwardAE/ForwardBE (select encoding consumed by the execute forwarding mux), decode-stage branch/jr forwarding, load-use/branch stalls and the E-stage flush.
- Tracks a multi-cycle mult/div unit so HI/LO reads and back-to-back issues stall until the unit is free.

Parameters:
- REG_W, 5, register-index width
- MULT_CYCLES, 4, busy cycles after a mult leaves D
- DIV_CYCLES, 32, busy cycles after a div leaves D

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- RsD  input  REG_W  rs index of instruction in D
- RtD  input  REG_W  rt index of instruction in D
- UseRsD  input  1  D instruction reads rs
- UseRtD  input  1  D instruction reads rt
- BranchD  input  1  beq/bne resolved in D (compares rs, rt)
- JrD  input  1  jr/jalr in D (reads rs in D)
- RegWriteD  input  1  D instruction writes a GPR
- MemtoRegD  input  1  D instruction is a load
- WriteRegD  input  REG_W  destination index of D instruction
- MdStartD  input  1  D instruction is mult/multu/div/divu
- MdDivD  input  1  qualifies MdStartD: 1 = div, 0 = mult
- MdReadD  input  1  D instruction is mfhi/mflo
- ForwardAE  output  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUOutM
- ForwardBE  output  2  WriteData select, same encoding
- ForwardAD  output  1  D-stage rs compare operand from ALUOutM
- ForwardBD  output  1  D-stage rt compare operand from ALUOutM
- StallF  output  1  hold PC
- StallD  output  1  hold IF/ID register
- FlushE  output  1  insert bubble into ID/EX
- MdBusy  output  1  mult/div unit busy

Behaviour:
- Shadow registers: E = {RsE, RtE, WriteRegE, RegWriteE, MemtoRegE}; M = {WriteRegM, RegWriteM, MemtoRegM}; W = {WriteRegW, RegWriteW}.
  - Every clk: E <- D inputs (Rs/Rt only when the matching Use bit is set, else 0); M <- E; W <- M.
  - When FlushE = 1, E loads all zeros (bubble). M and W always advance.
- Reset (rst_n = 0 at a clk edge): all shadow registers and the MD counter clear to 0.
  - Every output is 0 the following cycle. Reset wins over stall, flush and MD issue.
- ForwardAE, combinational from registered state:
  - 10 if RsE != 0 && RegWriteM && WriteRegM == RsE;
  - else 01 if RsE != 0 && RegWriteW && WriteRegW == RsE;
  - else 00.
  - M beats W when both match. ForwardBE is identical using RtE.
- ForwardAD = RsD != 0 && RegWriteM && !MemtoRegM && WriteRegM == RsD. ForwardBD uses RtD.
  - W-to-D is not forwarded; the register file writes in the first half-cycle.
- lwstall = RegWriteE && MemtoRegE && WriteRegE != 0 && ((UseRsD && RsD == WriteRegE) || (UseRtD && RtD == WriteRegE)).
- brstall applies when src is RsD/RtD for BranchD, or RsD only for JrD. It is set if src != 0 and either:
  - RegWriteE && WriteRegE == src; or
  - RegWriteM && MemtoRegM && WriteRegM == src.
- mdstall = MdBusy && (MdReadD || MdStartD).
- stall = lwstall | brstall | mdstall; StallF = StallD = FlushE = stall.
- MD counter (width clog2(DIV_CYCLES+1)):
  - If MdStartD && !stall: load DIV_CYCLES or MULT_CYCLES per MdDivD.
  - Else if nonzero: decrement.
  - MdBusy = counter != 0.
  - A div issue yields exactly DIV_CYCLES busy cycles. mfhi/mflo proceeds in the cycle the counter reads 0.
- Simultaneous events:
  - An MdStartD blocked by lw/branch stall does not load the counter; it loads when the instruction actually leaves D.
  - A start arriving while busy stalls, so it never restarts the counter.
- Indices equal to 0 never forward and never stall.

Decomposition:
- Package mips_hazard_pkg: FWD_REG = 2'b00, FWD_RESULTW = 2'b01, FWD_ALUOUTM = 2'b10, REG_ZERO, and a struct for the E/M/W shadow entries.
- One sub-module, md_busy_counter (load value, decrement, busy flag).
- Everything else stays flat in hazard_forward_ctrl.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 -> with sub in E, ForwardAE = 10, ForwardBE = 00, no stall.
- lw $2,0($1) then add $4,$2,$3 -> StallF = StallD = FlushE = 1 for exactly 1 cycle; add then in E with lw in W: ForwardAE = 01.
- addi $0,$1,5 then add $4,$0,$0 -> ForwardAE = ForwardBE = 00, no stall.
- add $3,... then beq $3,$5 -> 1 stall cycle, next cycle ForwardAD = 1, ForwardBD = 0. lw $3 then beq $3 -> 2 stall cycles.
- div $1,$2 then mflo $4 -> StallD high exactly 32 cycles, MdBusy falls in the same cycle as the stall releases. mult then mult -> second held 4 cycles.
- rst_n = 0 for one cycle mid-div (counter = 10) -> next cycle MdBusy = 0, all Forward* = 0, all stalls 0; prior E/M/W matches no longer forward.
